// File: rtl/stream_mux_n_pkg.sv
// Shared definitions for the stream_mux_n block.
// Holds the mode encodings used by the top level.
package stream_mux_n_pkg;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/stream_mux_n_rr.sv
// Rotating-priority picker: first set bit of req starting at ptr.
// Ports: req (N requests), ptr (start index) -> found, idx.
module rr_pick #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    int j;

    // Scan from the farthest offset down so the closest to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                found = 1'b1;
                idx   = SELW'(j);
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// Registered N-channel stream mux, static select or round-robin.
// Ports: clock, reset_n, mode, sel, in_data/in_valid/in_ready,
//        out_data/out_chan/out_valid/out_ready.
module stream_mux_n
    import stream_mux_n_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_chan,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_chan_q,  out_chan_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] ptr_q,       ptr_d;

    logic            load_en;
    logic            rr_found;
    logic [SELW-1:0] rr_idx;
    logic            cand_ok;
    logic [SELW-1:0] cand;
    logic [W-1:0]    cand_data;
    logic            cand_valid;
    logic            xfer;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr_q),
        .found (rr_found),
        .idx   (rr_idx)
    );

    always_comb begin
        load_en = !out_valid_q || out_ready;
        if (mode == MODE_RR) begin
            cand    = rr_idx;
            cand_ok = rr_found;
        end else begin
            cand    = sel;
            // sel may name a nonexistent channel when N is not 2**SELW
            cand_ok = (int'(sel) < N);
        end
    end

    always_comb begin
        cand_data  = '0;
        cand_valid = 1'b0;
        in_ready   = '0;
        for (int i = 0; i < N; i++) begin
            if (cand == SELW'(i)) begin
                cand_data  = in_data[i*W +: W];
                cand_valid = in_valid[i];
                in_ready[i] = cand_ok && load_en && reset_n;
            end
        end
        xfer = cand_ok && cand_valid && load_en;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = cand_data;
                out_chan_d = cand;
                ptr_d      = (int'(cand) == N - 1) ? '0 : cand + SELW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n (N=4, W=8).
// Scoreboard model predicts grants; scenario tasks add targeted checks.
module tb_stream_mux_n;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int SELW = 2;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              mode = 1'b1;
    logic [SELW-1:0]   sel = '0;
    logic [N*W-1:0]    in_data = {8'h0D, 8'h0C, 8'h0B, 8'h0A};
    logic [N-1:0]      in_valid = '1;
    logic [N-1:0]      in_ready;
    logic [W-1:0]      out_data;
    logic [SELW-1:0]   out_chan;
    logic              out_valid;
    logic              out_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [SELW+W-1:0] sb[$];
    int                ptr_m = 0;

    stream_mux_n #(.N(N), .W(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    // Reference model and scoreboard, evaluated mid-cycle.
    always @(negedge clock) begin
        logic              exp_ov;
        logic              load_m;
        logic              ok;
        int                c;
        int                j;
        logic [N-1:0]      exp_rdy;
        logic [SELW+W-1:0] fr;
        if (!reset_n) begin
            sb.delete();
            ptr_m = 0;
            checks++;
            if (in_ready !== '0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mon_reset: in_ready=%b out_valid=%b want 0/0",
                         in_ready, out_valid);
            end
        end else begin
            exp_ov = (sb.size() != 0);
            checks++;
            if (out_valid !== exp_ov) begin
                errors++;
                $display("FAIL mon_valid: got %b want %b", out_valid, exp_ov);
            end
            if (exp_ov) begin
                fr = sb[0];
                checks++;
                if ({out_chan, out_data} !== fr) begin
                    errors++;
                    $display("FAIL mon_beat: got ch%0d %h want ch%0d %h",
                             out_chan, out_data, fr[SELW+W-1:W], fr[W-1:0]);
                end
            end
            load_m = !exp_ov || out_ready;
            if (exp_ov && out_ready) void'(sb.pop_front());
            ok = 1'b0;
            c  = 0;
            if (mode) begin
                for (int k = 0; k < N; k++) begin
                    j = (ptr_m + k) % N;
                    if (!ok && in_valid[j]) begin
                        ok = 1'b1;
                        c  = j;
                    end
                end
            end else begin
                ok = 1'b1;
                c  = int'(sel);
            end
            exp_rdy = '0;
            if (ok && load_m) exp_rdy[c] = 1'b1;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL mon_ready: got %b want %b", in_ready, exp_rdy);
            end
            if (ok && load_m && in_valid[c]) begin
                sb.push_back({SELW'(c), in_data[c*W +: W]});
                ptr_m = (c == N - 1) ? 0 : c + 1;
            end
        end
    end

    task automatic test_reset();
        reset_n  = 1'b0;
        mode     = 1'b1;
        in_valid = '1;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (in_ready !== '0 || out_valid !== 1'b0 || out_data !== '0
            || out_chan !== '0) begin
            errors++;
            $display("FAIL reset_vals: rdy=%b ov=%b od=%h oc=%0d want 0",
                     in_ready, out_valid, out_data, out_chan);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_rdy: got %b want 0001", in_ready);
        end
        @(posedge clock); #1;
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'h0A) begin
            errors++;
            $display("FAIL reset_first_beat: ov=%b ch%0d %h want 1 ch0 0a",
                     out_valid, out_chan, out_data);
        end
    endtask

    task automatic test_static();
        logic [W-1:0] exp_d;
        mode = 1'b0;
        for (int s = 0; s < N; s++) begin
            sel = SELW'(s);
            @(posedge clock); #1;
            exp_d = 8'h0A + W'(s);
            checks++;
            if (out_data !== exp_d || out_chan !== SELW'(s)) begin
                errors++;
                $display("FAIL static_sel%0d: got ch%0d %h want ch%0d %h",
                         s, out_chan, out_data, s, exp_d);
            end
        end
    endtask

    task automatic test_rr_all();
        mode = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clock); #1;
            checks++;
            if (out_valid !== 1'b1 || out_chan !== SELW'(k % N)) begin
                errors++;
                $display("FAIL rr_seq%0d: ov=%b ch%0d want 1 ch%0d",
                         k, out_valid, out_chan, k % N);
            end
        end
    endtask

    task automatic test_backpressure();
        in_valid = 4'b0010;
        @(posedge clock); #1;
        checks++;
        if (out_data !== 8'h0B) begin
            errors++;
            $display("FAIL bp_load: got %h want 0b", out_data);
        end
        out_ready = 1'b0;
        in_valid  = '1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            checks++;
            if (out_data !== 8'h0B || out_valid !== 1'b1 || in_ready !== '0) begin
                errors++;
                $display("FAIL bp_hold%0d: od=%h ov=%b rdy=%b want 0b 1 0000",
                         k, out_data, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release_rdy: got %b want 0100", in_ready);
        end
        @(posedge clock); #1;
        checks++;
        if (out_data !== 8'h0C || out_chan !== 2'd2) begin
            errors++;
            $display("FAIL bp_release_beat: got ch%0d %h want ch2 0c",
                     out_chan, out_data);
        end
    endtask

    task automatic test_sparse_rr();
        logic [SELW-1:0] exp_ch [3];
        exp_ch = '{2'd3, 2'd1, 2'd3};
        // one static grant on ch1 leaves the pointer at 2
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'b0010;
        @(posedge clock); #1;
        mode     = 1'b1;
        in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ((in_ready & 4'b0101) !== '0) begin
                errors++;
                $display("FAIL sparse_idle%0d: rdy=%b want ch0/ch2 low",
                         k, in_ready);
            end
            @(posedge clock); #1;
            checks++;
            if (out_chan !== exp_ch[k] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sparse_grant%0d: ov=%b ch%0d want 1 ch%0d",
                         k, out_valid, out_chan, exp_ch[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        in_valid = '1;
        reset_n  = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== '0) begin
            errors++;
            $display("FAIL midrst_async: ov=%b rdy=%b want 0 0000",
                     out_valid, in_ready);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0) begin
            errors++;
            $display("FAIL midrst_ptr: ov=%b ch%0d want 1 ch0",
                     out_valid, out_chan);
        end
    endtask

    task automatic test_drain();
        in_valid = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: ov=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_rr_all();
        test_backpressure();
        test_sparse_rr();
        test_mid_reset();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
